// File: rtl/mips_instr_encoder.sv
// -----------------------------------------------------------------------------
// mips_instr_encoder
//
// Sequential instruction encoder and program loader for the single-cycle MIPS
// core. Symbolic requests arrive over a valid/ready handshake. Each one is
// encoded into a 32-bit MIPS word and written to the next consecutive
// instruction-memory word address, one cycle after the handshake.
//
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   start, base_addr    open a load session at base_addr (IDLE/DONE only)
//   finish              close the current session (LOAD/FULL only)
//   op_valid, op_ready  request handshake; op_ready is registered, high in LOAD
//   op_kind             0=R 1=addi 2=lw 3=sw 4=beq 5=j 6/7=illegal
//   rs..target          instruction fields
//   mem_we/addr/wdata   instruction-memory write port (held when mem_we=0)
//   count               words written this session (saturates at MAX_WORDS)
//   busy, done, err     session open / session closed / sticky illegal kind
// -----------------------------------------------------------------------------
module mips_instr_encoder #(
  parameter int ADDR_W    = 8,
  parameter int MAX_WORDS = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              finish,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [2:0]        op_kind,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [4:0]        rd,
  input  logic [4:0]        shamt,
  input  logic [5:0]        funct,
  input  logic [15:0]       imm,
  input  logic [25:0]       target,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, LOAD, FULL, DONE} state_t;

  localparam logic [ADDR_W+1:0] MAX_W = (ADDR_W+2)'(MAX_WORDS);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] ptr;
  logic [31:0]       enc_word;
  logic              xfer, legal, last, open_session;
  logic [ADDR_W+1:0] accepted_nxt;

  assign xfer         = op_valid && op_ready;
  assign legal        = (op_kind <= 3'd5);
  assign open_session = start && ((state == IDLE) || (state == DONE));

  // count only advances when a write retires, so a write still pending in
  // mem_we has to be included when deciding whether this transfer fills up.
  assign accepted_nxt = {1'b0, count} + (ADDR_W+2)'(mem_we) + (ADDR_W+2)'(1);
  assign last         = legal && (accepted_nxt == MAX_W);

  // Encoder: pure function of the request fields.
  always_comb begin
    // NOTE: default assignment first so no path leaves enc_word unassigned,
    // which would otherwise infer a latch.
    enc_word = '0;
    case (op_kind)
      3'd0:    enc_word = {6'h00, rs, rt, rd, shamt, funct};
      3'd1:    enc_word = {6'h08, rs, rt, imm};
      3'd2:    enc_word = {6'h23, rs, rt, imm};
      3'd3:    enc_word = {6'h2B, rs, rt, imm};
      3'd4:    enc_word = {6'h04, rs, rt, imm};
      3'd5:    enc_word = {6'h02, target};
      default: enc_word = '0;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: non-blocking assignments in clocked blocks so every register
    // samples pre-edge values regardless of statement order.
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic. finish wins over the FULL transition so a transfer
  // that arrives together with finish closes the session directly.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (start) state_nxt = LOAD;
      LOAD: begin
        if (finish)           state_nxt = DONE;
        else if (xfer && last) state_nxt = FULL;
      end
      FULL:       if (finish) state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
  end

  // Decoded state outputs.
  always_comb begin
    busy = (state == LOAD) || (state == FULL);
    done = (state == DONE);
  end

  // Datapath: handshake register, write port, pointer, count and err.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_ready  <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      ptr       <= '0;
      count     <= '0;
      err       <= 1'b0;
    end else begin
      // Registered ready tracks the state being entered.
      op_ready <= (state_nxt == LOAD);
      mem_we   <= xfer && legal;

      // ptr always points at the address the next accepted word will use;
      // it advances as the word is captured into the write register.
      if (xfer && legal) begin
        mem_addr  <= ptr;
        mem_wdata <= enc_word;
        ptr       <= ptr + ADDR_W'(1);
      end

      if (xfer && !legal) err <= 1'b1;

      if (mem_we) count <= count + (ADDR_W+1)'(1);

      // op_ready is low in IDLE/DONE, so no transfer can coincide with this.
      if (open_session) begin
        ptr   <= base_addr;
        count <= '0;
        err   <= 1'b0;
      end
    end
  end

endmodule
